// File: rtl/quat_renorm_pkg.sv
// Shared Q-format constants, FSM encoding and saturation helper
// for the quaternion renormalization block.
package quat_renorm_pkg;

    localparam logic signed [15:0] Q15_ONE = 16'sd32767;
    localparam logic signed [15:0] Q15_MIN = 16'sh8000;
    localparam logic [17:0] Q16_ONE = 18'd65536;
    localparam logic [33:0] NORM_LO = 34'd536870912;
    localparam logic [33:0] NORM_HI = 34'd1610612736;
    localparam logic [35:0] Q30_THREE = 36'd3221225472;

    typedef enum logic [2:0] {
        IDLE,
        TRUNC,
        NORM,
        NR_SQ,
        NR_UPD,
        SCALE,
        HOLD
    } state_t;

    function automatic logic signed [15:0] sat16(
        input logic signed [34:0] v
    );
        if (v > 35'sd32767) begin
            sat16 = Q15_ONE;
        end else if (v < -35'sd32768) begin
            sat16 = Q15_MIN;
        end else begin
            sat16 = v[15:0];
        end
    endfunction

endpackage

// File: rtl/quat_renorm_inv_sqrt.sv
// Newton-Raphson 1/sqrt(n) datapath: alternating square and update
// cycles, NR_ITERS iterations per start pulse, y in unsigned Q2.16.
module quat_inv_sqrt_nr
    import quat_renorm_pkg::*;
#(
    parameter int NR_ITERS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [33:0] n,
    output logic        done,
    output logic [17:0] y
);

    localparam logic [2:0] LAST = 3'(NR_ITERS - 1);

    logic        busy;
    logic        upd;
    logic [2:0]  cnt;
    logic [35:0] t;
    logic [35:0] y_sq;
    logic [69:0] t_prod;
    logic [35:0] t_next;
    logic [53:0] y_prod;
    logic [17:0] y_next;

    // t = n*y^2: Q30 * Q4.32 -> drop 32 fraction bits back to Q30
    assign y_sq   = {18'b0, y} * {18'b0, y};
    assign t_prod = {36'b0, n} * {34'b0, y_sq};
    assign t_next = 36'(t_prod >> 32);

    // y*(3-t)/2: Q16 * Q30 -> >>30 for Q16, one more for the halving
    assign y_prod = {36'b0, y} * {18'b0, Q30_THREE - t};
    assign y_next = 18'(y_prod >> 31);

    assign done = busy & upd & (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            upd  <= 1'b0;
            cnt  <= '0;
            t    <= '0;
            y    <= '0;
        end else if (start) begin
            busy <= 1'b1;
            upd  <= 1'b0;
            cnt  <= '0;
            t    <= '0;
            y    <= Q16_ONE;
        end else if (busy) begin
            if (!upd) begin
                t   <= t_next;
                upd <= 1'b1;
            end else begin
                y   <= y_next;
                upd <= 1'b0;
                if (cnt == LAST) begin
                    busy <= 1'b0;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/quat_renorm.sv
// Renormalizes a Q2.30 quaternion product to a Q1.15 unit quaternion,
// one item in flight, with identity fallback for out-of-range norms.
module quat_renorm
    import quat_renorm_pkg::*;
#(
    parameter int NR_ITERS = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [31:0] r1,
    input  logic signed [31:0] r2,
    input  logic signed [31:0] r3,
    input  logic signed [31:0] r4,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] q0,
    output logic signed [15:0] q1,
    output logic signed [15:0] q2,
    output logic signed [15:0] q3,
    output logic               err
);

    state_t state_q, state_d;

    logic signed [31:0] r_q [4];
    logic signed [15:0] x_q [4];
    logic signed [15:0] q_q [4];
    logic [33:0]        n_q;
    logic               err_q;
    logic               ov_q;

    logic signed [31:0] sh [4];
    logic signed [15:0] x_c [4];
    logic [31:0]        sq [4];
    logic signed [34:0] prod [4];
    logic signed [34:0] rnd [4];
    logic signed [15:0] q_c [4];
    logic [33:0]        n_c;
    logic               bad;
    logic               start;
    logic               nr_done;
    logic [17:0]        y_nr;
    logic [17:0]        y_s;

    quat_inv_sqrt_nr #(
        .NR_ITERS (NR_ITERS)
    ) u_nr (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .n     (n_q),
        .done  (nr_done),
        .y     (y_nr)
    );

    assign y_s = err_q ? Q16_ONE : y_nr;

    always_comb begin
        n_c = '0;
        for (int i = 0; i < 4; i++) begin
            sh[i]   = r_q[i] >>> 15;
            x_c[i]  = sat16({{3{sh[i][31]}}, sh[i]});
            sq[i]   = 32'($signed({{16{x_q[i][15]}}, x_q[i]})
                        * $signed({{16{x_q[i][15]}}, x_q[i]}));
            n_c     = n_c + {2'b0, sq[i]};
            prod[i] = $signed({{19{x_q[i][15]}}, x_q[i]})
                      * $signed({17'b0, y_s});
            rnd[i]  = (prod[i] + 35'sd32768) >>> 16;
            q_c[i]  = sat16(rnd[i]);
        end
        bad = (n_c < NORM_LO) || (n_c >= NORM_HI);
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = TRUNC;
            TRUNC:   state_d = NORM;
            NORM: begin
                if (bad) begin
                    state_d = SCALE;
                end else begin
                    start   = 1'b1;
                    state_d = NR_SQ;
                end
            end
            NR_SQ:   state_d = NR_UPD;
            NR_UPD:  state_d = nr_done ? SCALE : NR_SQ;
            SCALE:   state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ov_q    <= 1'b0;
            err_q   <= 1'b0;
            n_q     <= '0;
            for (int i = 0; i < 4; i++) begin
                r_q[i] <= '0;
                x_q[i] <= '0;
                q_q[i] <= (i == 0) ? Q15_ONE : 16'sd0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && in_valid) begin
                r_q[0] <= r1;
                r_q[1] <= r2;
                r_q[2] <= r3;
                r_q[3] <= r4;
            end
            if (state_q == TRUNC) begin
                for (int i = 0; i < 4; i++) x_q[i] <= x_c[i];
            end
            if (state_q == NORM) begin
                n_q   <= n_c;
                err_q <= bad;
                // identity x with y = 1.0 makes SCALE emit (32767,0,0,0)
                if (bad) begin
                    for (int i = 0; i < 4; i++) begin
                        x_q[i] <= (i == 0) ? Q15_ONE : 16'sd0;
                    end
                end
            end
            if (state_q == SCALE) begin
                for (int i = 0; i < 4; i++) q_q[i] <= q_c[i];
                ov_q <= 1'b1;
            end
            if (state_q == HOLD && out_ready) begin
                ov_q <= 1'b0;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = ov_q;
    assign err       = err_q;
    assign q0        = q_q[0];
    assign q1        = q_q[1];
    assign q2        = q_q[2];
    assign q3        = q_q[3];

endmodule
